// File: rtl/reg_scoreboard_pkg.sv
// Shared register-file geometry and hazard helper for the issue-side scoreboard.
// Imported by the scoreboard top and its saturating counter.
package reg_scoreboard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int XLEN       = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // x0 is hardwired zero, so reading it can never depend on an in-flight write
    function automatic logic hazard(input logic [NUM_REGS-1:0] mask,
                                    input logic [REG_ADDR_W-1:0] rs);
        return (rs != REG_ZERO) && mask[rs];
    endfunction

endpackage

// File: rtl/reg_scoreboard_sat_counter.sv
// Saturating up-counter with synchronous reset; holds at all-ones.
module reg_scoreboard_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_C = '1;

    logic [WIDTH-1:0] count_r;

    // count register: clears on reset, stops at the top value
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (inc && (count_r != MAX_C)) begin
            count_r <= count_r + WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/reg_scoreboard.sv
// Issue-side register scoreboard: tracks in-flight destination writes, holds issue on
// RAW/WAW hazards or when the in-flight budget is used, and drives the regfile write port.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   issueValid,
    input  logic [REG_ADDR_W-1:0]                  issueRs1,
    input  logic [REG_ADDR_W-1:0]                  issueRs2,
    input  logic [REG_ADDR_W-1:0]                  issueRd,
    input  logic                                   issueUsesRd,
    output logic                                   issueReady,
    input  logic                                   wbValid,
    input  logic [REG_ADDR_W-1:0]                  wbRd,
    input  logic [XLEN-1:0]                        wbData,
    output logic                                   rfIsWrite,
    output logic [REG_ADDR_W-1:0]                  rfRd,
    output logic [XLEN-1:0]                        rfWriteData,
    output logic [NUM_REGS-1:0]                    pendingMask,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic [CNT_W-1:0]                       stallCount,
    output logic                                   wbError
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0]    MAX_OUT_C  = OUT_W'(MAX_OUTSTANDING);
    localparam logic [NUM_REGS-1:0] X0_KEEP_C  = ~{{(NUM_REGS-1){1'b0}}, 1'b1};

    logic [NUM_REGS-1:0] pending_r;
    logic [NUM_REGS-1:0] pending_nxt_s;
    logic [NUM_REGS-1:0] set_vec_s;
    logic [NUM_REGS-1:0] clr_vec_s;
    logic [OUT_W-1:0]    outstanding_r;
    logic [OUT_W-1:0]    outstanding_nxt_s;
    logic                wb_error_r;

    logic dest_s;
    logic haz_raw_s;
    logic haz_waw_s;
    logic full_s;
    logic ready_s;
    logic set_s;
    logic wb_live_s;
    logic clr_s;
    logic wb_err_s;
    logic stall_s;

    // Hazards look only at registered pending state; a same-cycle writeback releases next cycle.
    assign dest_s    = issueUsesRd && (issueRd != REG_ZERO);
    assign haz_raw_s = hazard(pending_r, issueRs1) || hazard(pending_r, issueRs2);
    assign haz_waw_s = dest_s && pending_r[issueRd];
    assign full_s    = dest_s && (outstanding_r == MAX_OUT_C);
    assign ready_s   = !haz_raw_s && !haz_waw_s && !full_s;
    assign set_s     = issueValid && ready_s && dest_s;
    assign stall_s   = issueValid && !ready_s;

    assign wb_live_s = wbValid && (wbRd != REG_ZERO);
    assign clr_s     = wb_live_s && pending_r[wbRd];
    assign wb_err_s  = wb_live_s && !pending_r[wbRd];

    assign set_vec_s     = set_s ? (NUM_REGS'(1) << issueRd) : '0;
    assign clr_vec_s     = clr_s ? (NUM_REGS'(1) << wbRd) : '0;
    assign pending_nxt_s = (pending_r | set_vec_s) & ~clr_vec_s & X0_KEEP_C;

    // outstanding tracks popcount of the pending mask through set/clear events
    always_comb begin
        outstanding_nxt_s = outstanding_r;
        case ({set_s, clr_s})
            2'b10:   outstanding_nxt_s = outstanding_r + OUT_W'(1);
            2'b01:   outstanding_nxt_s = outstanding_r - OUT_W'(1);
            default: outstanding_nxt_s = outstanding_r;
        endcase
    end

    // pending/outstanding/error state; reset wins over same-cycle issue or writeback
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r     <= '0;
            outstanding_r <= '0;
            wb_error_r    <= 1'b0;
        end else begin
            pending_r     <= pending_nxt_s;
            outstanding_r <= outstanding_nxt_s;
            wb_error_r    <= wb_error_r | wb_err_s;
        end
    end

    reg_scoreboard_sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_s),
        .count (stallCount)
    );

    assign issueReady  = ready_s;
    assign rfIsWrite   = wb_live_s;
    assign rfRd        = wbRd;
    assign rfWriteData = wbData;
    assign pendingMask = pending_r;
    assign outstanding = outstanding_r;
    assign wbError     = wb_error_r;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scenario bench for reg_scoreboard: per-cycle stimulus tables, expected snapshots queued
// at drive time and popped when the cycle's outputs are sampled.
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    localparam int MAXO = 4;
    localparam int CW   = 4;
    localparam int OW   = $clog2(MAXO + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          issueValid;
    logic [4:0]    issueRs1, issueRs2, issueRd;
    logic          issueUsesRd;
    logic          issueReady;
    logic          wbValid;
    logic [4:0]    wbRd;
    logic [31:0]   wbData;
    logic          rfIsWrite;
    logic [4:0]    rfRd;
    logic [31:0]   rfWriteData;
    logic [31:0]   pendingMask;
    logic [OW-1:0] outstanding;
    logic [CW-1:0] stallCount;
    logic          wbError;

    always #5 clk = ~clk;

    reg_scoreboard #(.MAX_OUTSTANDING(MAXO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .issueValid(issueValid), .issueRs1(issueRs1), .issueRs2(issueRs2),
        .issueRd(issueRd), .issueUsesRd(issueUsesRd), .issueReady(issueReady),
        .wbValid(wbValid), .wbRd(wbRd), .wbData(wbData),
        .rfIsWrite(rfIsWrite), .rfRd(rfRd), .rfWriteData(rfWriteData),
        .pendingMask(pendingMask), .outstanding(outstanding),
        .stallCount(stallCount), .wbError(wbError)
    );

    typedef struct packed {
        logic        ready;
        logic        rfw;
        logic [4:0]  rfrd;
        logic [31:0] rfdata;
        logic [31:0] mask;
        logic [2:0]  outst;
        logic [31:0] stall;
        logic        err;
    } snap_t;

    typedef struct {
        logic        rst, iv;
        logic [4:0]  rs1, rs2, rd;
        logic        uses, wbv;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
        snap_t       exp;
    } step_t;

    int    n_cmp = 0;
    int    n_bad = 0;
    snap_t exp_q[$];

    function automatic step_t S(input logic r, input logic iv, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd, input logic uses,
                                input logic wbv, input logic [4:0] wbrd, input logic [31:0] wbd,
                                input logic ready, input logic [31:0] mask, input int outst,
                                input int stall, input logic err);
        step_t s;
        s.rst = r; s.iv = iv; s.rs1 = rs1; s.rs2 = rs2; s.rd = rd; s.uses = uses;
        s.wbv = wbv; s.wbrd = wbrd; s.wbd = wbd;
        s.exp.ready  = ready;
        s.exp.rfw    = wbv && (wbrd != 5'd0);
        s.exp.rfrd   = wbrd;
        s.exp.rfdata = wbd;
        s.exp.mask   = mask;
        s.exp.outst  = 3'(outst);
        s.exp.stall  = 32'(stall);
        s.exp.err    = err;
        return s;
    endfunction

    function automatic snap_t snap();
        snap_t o;
        o.ready = issueReady; o.rfw = rfIsWrite; o.rfrd = rfRd; o.rfdata = rfWriteData;
        o.mask = pendingMask; o.outst = 3'(outstanding); o.stall = 32'(stallCount);
        o.err = wbError;
        return o;
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf("rdy=%0b rfw=%0b rfrd=%0d wdata=%h mask=%h outst=%0d stall=%0d err=%0b",
                         s.ready, s.rfw, s.rfrd, s.rfdata, s.mask, s.outst, s.stall, s.err);
    endfunction

    task automatic drive(input step_t s);
        rst = s.rst; issueValid = s.iv; issueRs1 = s.rs1; issueRs2 = s.rs2;
        issueRd = s.rd; issueUsesRd = s.uses; wbValid = s.wbv; wbRd = s.wbrd; wbData = s.wbd;
    endtask

    task automatic do_reset();
        drive(S(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        step_t st[$];
        snap_t got, want;
        do_reset();
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0,            1, 32'h0, 0, 0, 0));
        st.push_back(S(1, 1, 0, 0, 5, 1, 1, 9, 32'h11112222, 1, 32'h0, 0, 0, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0,            1, 32'h0, 0, 0, 0));
        foreach (st[i]) begin
            drive(st[i]); exp_q.push_back(st[i].exp);
            #1; got = snap(); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++; $display("FAIL reset[%0d]: got %s want %s", i, fmt(got), fmt(want));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_raw();
        step_t st[$];
        snap_t got, want;
        do_reset();
        st.push_back(S(0, 1, 0, 0, 5, 1, 0, 0, 0,            1, 32'h0,  0, 0, 0));
        st.push_back(S(0, 1, 5, 0, 0, 0, 0, 0, 0,            0, 32'h20, 1, 0, 0));
        st.push_back(S(0, 1, 0, 5, 0, 0, 0, 0, 0,            0, 32'h20, 1, 1, 0));
        st.push_back(S(0, 1, 5, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 32'h20, 1, 2, 0));
        st.push_back(S(0, 1, 5, 0, 0, 0, 0, 0, 0,            1, 32'h0,  0, 3, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0,            1, 32'h0,  0, 3, 0));
        foreach (st[i]) begin
            drive(st[i]); exp_q.push_back(st[i].exp);
            #1; got = snap(); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++; $display("FAIL raw[%0d]: got %s want %s", i, fmt(got), fmt(want));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_waw_x0();
        step_t st[$];
        snap_t got, want;
        do_reset();
        st.push_back(S(0, 1, 0, 0, 7, 1, 0, 0, 0,        1, 32'h0,  0, 0, 0));
        st.push_back(S(0, 1, 0, 0, 7, 1, 0, 0, 0,        0, 32'h80, 1, 0, 0));
        st.push_back(S(0, 1, 0, 0, 7, 1, 1, 7, 32'h1234, 0, 32'h80, 1, 1, 0));
        st.push_back(S(0, 1, 0, 0, 7, 1, 0, 0, 0,        1, 32'h0,  0, 2, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0,        1, 32'h80, 1, 2, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 1, 7, 32'h5678, 1, 32'h80, 1, 2, 0));
        st.push_back(S(0, 1, 0, 0, 0, 1, 0, 0, 0,        1, 32'h0,  0, 2, 0));
        st.push_back(S(0, 1, 0, 0, 0, 1, 0, 0, 0,        1, 32'h0,  0, 2, 0));
        st.push_back(S(0, 1, 0, 0, 0, 1, 0, 0, 0,        1, 32'h0,  0, 2, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0,        1, 32'h0,  0, 2, 0));
        foreach (st[i]) begin
            drive(st[i]); exp_q.push_back(st[i].exp);
            #1; got = snap(); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++; $display("FAIL waw_x0[%0d]: got %s want %s", i, fmt(got), fmt(want));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_full();
        step_t st[$];
        snap_t got, want;
        do_reset();
        st.push_back(S(0, 1, 0, 0, 1, 1, 0, 0, 0,     1, 32'h0,  0, 0, 0));
        st.push_back(S(0, 1, 0, 0, 2, 1, 0, 0, 0,     1, 32'h2,  1, 0, 0));
        st.push_back(S(0, 1, 0, 0, 3, 1, 0, 0, 0,     1, 32'h6,  2, 0, 0));
        st.push_back(S(0, 1, 0, 0, 4, 1, 0, 0, 0,     1, 32'hE,  3, 0, 0));
        st.push_back(S(0, 1, 0, 0, 6, 1, 0, 0, 0,     0, 32'h1E, 4, 0, 0));
        st.push_back(S(0, 1, 0, 0, 6, 0, 0, 0, 0,     1, 32'h1E, 4, 1, 0));
        st.push_back(S(0, 1, 0, 0, 6, 1, 1, 2, 32'hA, 0, 32'h1E, 4, 1, 0));
        st.push_back(S(0, 1, 0, 0, 6, 1, 1, 3, 32'hB, 1, 32'h1A, 3, 2, 0));
        st.push_back(S(0, 1, 0, 0, 3, 1, 0, 0, 0,     1, 32'h52, 3, 2, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0,     1, 32'h5A, 4, 2, 0));
        st.push_back(S(0, 1, 0, 0, 9, 1, 0, 0, 0,     0, 32'h5A, 4, 2, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0,     1, 32'h5A, 4, 3, 0));
        foreach (st[i]) begin
            drive(st[i]); exp_q.push_back(st[i].exp);
            #1; got = snap(); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++; $display("FAIL full[%0d]: got %s want %s", i, fmt(got), fmt(want));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_spurious_wb();
        step_t st[$];
        snap_t got, want;
        do_reset();
        st.push_back(S(0, 0, 0, 0, 0, 0, 1, 0, 32'h0BADF00D, 1, 32'h0, 0, 0, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0,            1, 32'h0, 0, 0, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 1, 9, 32'hCAFEF00D, 1, 32'h0, 0, 0, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0,            1, 32'h0, 0, 0, 1));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0,            1, 32'h0, 0, 0, 1));
        st.push_back(S(1, 0, 0, 0, 0, 0, 0, 0, 0,            1, 32'h0, 0, 0, 1));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0,            1, 32'h0, 0, 0, 0));
        foreach (st[i]) begin
            drive(st[i]); exp_q.push_back(st[i].exp);
            #1; got = snap(); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++; $display("FAIL spurious_wb[%0d]: got %s want %s", i, fmt(got), fmt(want));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall_sat();
        step_t st[$];
        snap_t got, want;
        do_reset();
        st.push_back(S(0, 1, 0, 0, 5, 1, 0, 0, 0, 1, 32'h0, 0, 0, 0));
        for (int k = 1; k <= 20; k++)
            st.push_back(S(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 32'h20, 1, (k - 1 > 15) ? 15 : k - 1, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h20, 1, 15, 0));
        foreach (st[i]) begin
            drive(st[i]); exp_q.push_back(st[i].exp);
            #1; got = snap(); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++; $display("FAIL stall_sat[%0d]: got %s want %s", i, fmt(got), fmt(want));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        step_t st[$];
        snap_t got, want;
        do_reset();
        st.push_back(S(0, 1, 0, 0, 3, 1, 0, 0, 0, 1, 32'h0, 0, 0, 0));
        st.push_back(S(0, 1, 0, 0, 8, 1, 0, 0, 0, 1, 32'h8, 1, 0, 0));
        for (int k = 0; k < 10; k++)
            st.push_back(S(0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 32'h108, 2, k, 0));
        st.push_back(S(1, 1, 0, 0, 12, 1, 1, 8, 32'h77, 1, 32'h108, 2, 10, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0,       1, 32'h0,   0, 0,  0));
        st.push_back(S(0, 1, 0, 0, 12, 1, 0, 0, 0,      1, 32'h0,   0, 0,  0));
        foreach (st[i]) begin
            drive(st[i]); exp_q.push_back(st[i].exp);
            #1; got = snap(); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++; $display("FAIL reset_mid[%0d]: got %s want %s", i, fmt(got), fmt(want));
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_raw();
        test_waw_x0();
        test_full();
        test_spurious_wb();
        test_stall_sat();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
